// File: rtl/gs_pkg.sv
// Shared state encoding, funct3 size codes and address helper for the gs memory arbiter.
package gs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_IF,
        ST_ISSUE_DM,
        ST_RESP_IF,
        ST_RESP_DM
    } mem_arb_state_t;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/gs_lsu_align.sv
// Load/store lane logic: byte enables, store lane placement, load sign/zero extension.
// With GS_MISALIGN_TRAP_EN the misalign flag is live; otherwise accesses align down and illegal sizes act as word.
module gs_lsu_align
    import gs_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misalign
);
    logic [1:0]  lane;
    logic [15:0] picked;

    always_comb begin
        lane       = 2'b00;
        be         = 4'b1111;
        wdata_lane = wdata;
        case (size)
            SZ_B, SZ_BU: begin
                lane       = offset;
                be         = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
            end
            SZ_H, SZ_HU: begin
                lane       = {offset[1], 1'b0};
                be         = 4'b0011 << lane;
                wdata_lane = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Bring the addressed byte/half down to bit 0 before extending.
    assign picked = 16'(rdata >> {lane, 3'b000});

    always_comb begin
        case (size)
            SZ_B:    rdata_ext = {{24{picked[7]}}, picked[7:0]};
            SZ_BU:   rdata_ext = {24'h0, picked[7:0]};
            SZ_H:    rdata_ext = {{16{picked[15]}}, picked};
            SZ_HU:   rdata_ext = {16'h0, picked};
            default: rdata_ext = rdata;
        endcase
    end

`ifdef GS_MISALIGN_TRAP_EN
    always_comb begin
        case (size)
            SZ_B, SZ_BU: misalign = 1'b0;
            SZ_H, SZ_HU: misalign = offset[0];
            SZ_W:        misalign = |offset;
            default:     misalign = 1'b1;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/gs_mem_arbiter.sv
// Shares the single memory port between fetch and load/store, one transaction outstanding.
// Optional GS_MISALIGN_TRAP_EN: misaligned/illegal data accesses complete without touching memory.
module gs_mem_arbiter
    import gs_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [2:0]  dm_size,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_valid,
    output logic [31:0] dm_rdata,
    output logic        dm_misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    mem_arb_state_t state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        trap_q, trap_d;
    logic        grant_if, grant_dm;

    logic [2:0]  al_size;
    logic [1:0]  al_off;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_misalign;

    // In IDLE the aligner looks at the live request; afterwards at the captured size/offset.
    assign al_size = (state_q == ST_IDLE) ? dm_size      : size_q;
    assign al_off  = (state_q == ST_IDLE) ? dm_addr[1:0] : off_q;

    gs_lsu_align u_align (
        .size       (al_size),
        .offset     (al_off),
        .wdata      (dm_wdata),
        .rdata      (mem_rdata),
        .be         (al_be),
        .wdata_lane (al_wdata),
        .rdata_ext  (al_rdata),
        .misalign   (al_misalign)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            starve_q <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            off_q    <= '0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            off_q    <= off_d;
            trap_q   <= trap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        off_d    = off_q;
        trap_d   = trap_q;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if_valid = 1'b0;
        dm_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant_if = if_req && (!dm_req || starve_q == LIMIT);
                grant_dm = dm_req && !grant_if;
                if (grant_if) begin
                    state_d  = ST_ISSUE_IF;
                    req_d    = 1'b1;
                    we_d     = 1'b0;
                    addr_d   = word_align(if_addr);
                    be_d     = 4'b1111;
                    wdata_d  = '0;
                    trap_d   = 1'b0;
                    starve_d = '0;
                end else if (grant_dm) begin
                    size_d = dm_size;
                    off_d  = dm_addr[1:0];
                    // A trapped access skips the bus and reports in RESP_DM next cycle.
                    if (al_misalign) begin
                        state_d = ST_RESP_DM;
                        req_d   = 1'b0;
                        trap_d  = 1'b1;
                    end else begin
                        state_d = ST_ISSUE_DM;
                        req_d   = 1'b1;
                        we_d    = dm_we;
                        addr_d  = word_align(dm_addr);
                        be_d    = al_be;
                        wdata_d = dm_we ? al_wdata : '0;
                        trap_d  = 1'b0;
                        if (if_req && starve_q != LIMIT) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                end
            end
            ST_ISSUE_IF: begin
                if (mem_gnt) begin
                    req_d   = 1'b0;
                    state_d = ST_RESP_IF;
                end
            end
            ST_ISSUE_DM: begin
                if (mem_gnt) begin
                    req_d   = 1'b0;
                    state_d = ST_RESP_DM;
                end
            end
            ST_RESP_IF: begin
                if (mem_rvalid) begin
                    if_valid = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_RESP_DM: begin
                if (trap_q || mem_rvalid) begin
                    dm_valid = 1'b1;
                    trap_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_be      = be_q;
    assign mem_wdata   = wdata_q;
    assign if_rdata    = if_valid ? mem_rdata : '0;
    assign dm_rdata    = (dm_valid && !trap_q && !we_q) ? al_rdata : '0;
    assign dm_misalign = dm_valid && trap_q;

endmodule

// File: tb/tb_gs_mem_arbiter.sv
// Directed bench for gs_mem_arbiter with a transaction-level reference model checked every cycle.
module tb_gs_mem_arbiter;
    import gs_pkg::*;

    localparam int STARVE_LIMIT = 4;
`ifdef GS_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_valid, dm_misalign;
    logic [2:0]  dm_size;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int errors = 0;
    int checks = 0;

    // responder controls
    logic [31:0] mem_word;
    int          gnt_stall = 0;
    int          rv_lat = 1;
    int          rv_cnt = 0;
    logic        force_rv = 1'b0;

    // model state
    bit          m_busy, m_want_req, m_resp, m_trap, m_is_if, m_we;
    logic [31:0] m_addr, m_wdata, m_daddr;
    logic [3:0]  m_be;
    logic [2:0]  m_size;
    int          m_starve;

    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;
    bit          log_en = 1'b0;
    bit          grant_log[$];

    always #5 clk = ~clk;
    assign mem_rdata = mem_word;

    gs_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_misalign(dm_misalign),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] sz);
        case (sz[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit legal(input logic [2:0] sz);
        return sz inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    function automatic int lane_off(input logic [2:0] sz, input logic [31:0] a);
        int o;
        o = int'(a[1:0]);
        return o - (o % nbytes(sz));
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] sz, input logic [31:0] a);
        return 4'(((1 << nbytes(sz)) - 1) << lane_off(sz, a));
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] raw);
        logic [31:0] v, m;
        int n;
        n = nbytes(sz);
        if (n == 4) return raw;
        m = (32'h1 << (8 * n)) - 32'h1;
        v = (raw >> (8 * lane_off(sz, a))) & m;
        if (!sz[2] && v[8 * n - 1]) v = v | ~m;
        return v;
    endfunction

    function automatic bit misaligned(input logic [2:0] sz, input logic [31:0] a);
        return !legal(sz) || ((int'(a[1:0]) % nbytes(sz)) != 0);
    endfunction

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    // memory responder: grant after gnt_stall cycles, answer rv_lat cycles after grant
    initial begin
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mem_gnt = 1'b0;
            mem_rvalid = force_rv;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) mem_rvalid = 1'b1;
            end else if (mem_req) begin
                if (gnt_stall > 0) gnt_stall--;
                else begin
                    mem_gnt = 1'b1;
                    rv_cnt = rv_lat;
                end
            end
        end
    end

    // per-cycle comparison against the reference model
    initial begin
        bit busy0, exp_ifv, exp_dmv, take_if;
        m_busy = 0; m_want_req = 0; m_resp = 0; m_trap = 0; m_starve = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("rst_ctrl", {27'b0, if_valid, dm_valid, dm_misalign, mem_req, mem_we}, 32'h0);
                check("rst_addr", mem_addr, 32'h0);
                check("rst_be", {28'b0, mem_be}, 32'h0);
                check("rst_data", mem_wdata | if_rdata | dm_rdata, 32'h0);
                m_busy = 0; m_want_req = 0; m_resp = 0; m_trap = 0; m_starve = 0;
                continue;
            end
            busy0 = m_busy;
            check("mem_req", {31'b0, mem_req}, {31'b0, m_want_req});
            if (m_want_req && mem_req) begin
                check("mem_addr", mem_addr, m_addr);
                check("mem_we", {31'b0, mem_we}, {31'b0, m_we});
                check("mem_be", {28'b0, mem_be}, {28'b0, m_be});
                if (m_we) check("mem_wdata", mem_wdata & be_mask(m_be), m_wdata & be_mask(m_be));
            end
            exp_ifv = m_resp && m_is_if && mem_rvalid;
            exp_dmv = (m_resp && !m_is_if && mem_rvalid) || m_trap;
            check("if_valid", {31'b0, if_valid}, {31'b0, exp_ifv});
            check("dm_valid", {31'b0, dm_valid}, {31'b0, exp_dmv});
            if (exp_dmv) check("dm_misalign", {31'b0, dm_misalign}, {31'b0, m_trap});
            if (exp_ifv) check("if_rdata", if_rdata, mem_rdata);
            if (exp_dmv) check("dm_rdata", dm_rdata,
                               (m_trap || m_we) ? 32'h0 : exp_load(m_size, m_daddr, mem_rdata));
            if (m_want_req && mem_gnt) begin
                m_want_req = 0;
                m_resp = 1;
                seen_addr = mem_addr;
                seen_be = mem_be;
                seen_wdata = mem_wdata;
                if (log_en) grant_log.push_back(mem_addr == 32'h1000);
            end
            if (exp_ifv || exp_dmv) begin
                m_resp = 0;
                m_trap = 0;
                m_busy = 0;
            end
            if (!busy0 && (if_req || dm_req)) begin
                take_if = if_req && (!dm_req || m_starve == STARVE_LIMIT);
                m_busy = 1;
                if (take_if) begin
                    m_is_if = 1; m_want_req = 1; m_we = 0; m_be = 4'hF;
                    m_addr = if_addr & 32'hFFFF_FFFC;
                    m_starve = 0;
                end else begin
                    m_is_if = 0; m_size = dm_size; m_daddr = dm_addr; m_we = dm_we;
                    if (TRAP_EN && misaligned(dm_size, dm_addr)) m_trap = 1;
                    else begin
                        m_want_req = 1;
                        m_addr = dm_addr & 32'hFFFF_FFFC;
                        m_be = exp_be(dm_size, dm_addr);
                        m_wdata = dm_wdata << (8 * lane_off(dm_size, dm_addr));
                        if (if_req && m_starve < STARVE_LIMIT) m_starve++;
                    end
                end
            end
        end
    end

    task automatic wait_valid(input bit for_if, input int limit, output int lat,
                              output logic [31:0] rd, output logic mis);
        lat = 0; rd = '0; mis = 1'b0;
        forever begin
            @(negedge clk);
            lat++;
            if (for_if ? if_valid : dm_valid) begin
                rd = for_if ? if_rdata : dm_rdata;
                mis = dm_misalign;
                return;
            end
            if (lat >= limit) begin
                check("valid_timeout", 32'h0, 32'h1);
                return;
            end
        end
    endtask

    task automatic do_if(input logic [31:0] a, input logic [31:0] word,
                         output int lat, output logic [31:0] rd);
        logic mis;
        mem_word = word; if_addr = a; if_req = 1'b1;
        wait_valid(1'b1, 40, lat, rd, mis);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic do_dm(input logic we, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] raw,
                         output int lat, output logic [31:0] rd, output logic mis);
        mem_word = raw; dm_we = we; dm_size = sz; dm_addr = a; dm_wdata = wd; dm_req = 1'b1;
        wait_valid(1'b0, 40, lat, rd, mis);
        @(posedge clk); #1;
        dm_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, n, cnt;
        logic [31:0] rd;
        logic mis;
        rst = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_size = '0; dm_addr = '0; dm_wdata = '0; mem_word = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("idle_mem_req", {31'b0, mem_req}, 32'h0);

        // fetch only, minimum latency
        do_if(32'h100, 32'h0050_0093, lat, rd);
        check("if_latency", lat, 3);
        check("if_rdata_lit", rd, 32'h0050_0093);
        check("if_addr_lit", seen_addr, 32'h100);
        check("if_be_lit", {28'b0, seen_be}, 32'hF);

        // byte loads, signed and unsigned
        do_dm(1'b0, SZ_B, 32'h203, 32'h0, 32'h80FF_FFFF, lat, rd, mis);
        check("lb_be", {28'b0, seen_be}, 32'h8);
        check("lb_rdata", rd, 32'hFFFF_FF80);
        do_dm(1'b0, SZ_BU, 32'h203, 32'h0, 32'h80FF_FFFF, lat, rd, mis);
        check("lbu_rdata", rd, 32'h0000_0080);

        // halfword store
        do_dm(1'b1, SZ_H, 32'h302, 32'h0000_ABCD, 32'h1111_1111, lat, rd, mis);
        check("sh_addr", seen_addr, 32'h300);
        check("sh_be", {28'b0, seen_be}, 32'hC);
        check("sh_wdata_hi", {16'b0, seen_wdata[31:16]}, 32'hABCD);
        check("sh_rdata", rd, 32'h0);

        // more lane patterns
        do_dm(1'b0, SZ_H, 32'h202, 32'h0, 32'h8001_7F00, lat, rd, mis);
        check("lh_rdata", rd, 32'hFFFF_8001);
        do_dm(1'b0, SZ_HU, 32'h202, 32'h0, 32'h8001_7F00, lat, rd, mis);
        check("lhu_rdata", rd, 32'h0000_8001);
        do_dm(1'b1, SZ_B, 32'h101, 32'h0000_005A, 32'h0, lat, rd, mis);
        check("sb_be", {28'b0, seen_be}, 32'h2);
        check("sb_lane", {24'b0, seen_wdata[15:8]}, 32'h5A);
        do_dm(1'b0, SZ_W, 32'h204, 32'h0, 32'hDEAD_BEEF, lat, rd, mis);
        check("lw_rdata", rd, 32'hDEAD_BEEF);

        // rvalid while idle is ignored
        @(negedge clk) force_rv = 1'b1;
        repeat (2) @(negedge clk);
        force_rv = 1'b0;
        @(posedge clk); #1;

        // grant stall with stray rvalid during issue
        gnt_stall = 5;
        mem_word = 32'hCAFE_F00D; dm_we = 1'b0; dm_size = SZ_W; dm_addr = 32'h700; dm_req = 1'b1;
        fork
            begin
                @(negedge clk) force_rv = 1'b1;
                repeat (3) @(negedge clk);
                force_rv = 1'b0;
            end
            wait_valid(1'b0, 40, lat, rd, mis);
        join
        @(posedge clk); #1;
        dm_req = 1'b0;
        check("stall_latency", lat, 8);
        check("stall_rdata", rd, 32'hCAFE_F00D);

        // contention with both requests held
        if_addr = 32'h1000; dm_we = 1'b0; dm_size = SZ_W; dm_addr = 32'h2000; mem_word = 32'h0F0F_0F0F;
        log_en = 1'b1; grant_log.delete();
        if_req = 1'b1; dm_req = 1'b1;
        cnt = 0; n = 0;
        while (cnt < 10 && n < 100) begin
            @(negedge clk);
            n++;
            if (if_valid || dm_valid) cnt++;
        end
        @(posedge clk); #1;
        if_req = 1'b0; dm_req = 1'b0; log_en = 1'b0;
        check("contention_count", grant_log.size(), 10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            check($sformatf("grant_%0d_is_if", i), {31'b0, grant_log[i]}, (i % 5 == 4) ? 32'h1 : 32'h0);
        @(posedge clk); #1;

        // request dropped after grant still completes
        mem_word = 32'h0000_F000; dm_we = 1'b0; dm_size = SZ_B; dm_addr = 32'h501; dm_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(mem_req && mem_gnt) && n < 20);
        @(posedge clk); #1;
        dm_req = 1'b0;
        wait_valid(1'b0, 20, lat, rd, mis);
        check("drop_rdata", rd, 32'hFFFF_FFF0);
        @(posedge clk); #1;

        // reset while waiting for the response, late rvalid after release
        rv_lat = 3;
        mem_word = 32'h1234_5678; dm_we = 1'b0; dm_size = SZ_W; dm_addr = 32'h600; dm_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(mem_req && mem_gnt) && n < 20);
        @(posedge clk); #2;
        rst = 1'b0; dm_req = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (dm_valid) cnt++;
        end
        check("rst_no_dm_valid", cnt, 0);
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        rv_lat = 1;
        @(posedge clk); #1;
        do_if(32'h104, 32'h0000_0013, lat, rd);
        check("post_rst_latency", lat, 3);

        // misaligned word load
        do_dm(1'b0, SZ_W, 32'h402, 32'h0, 32'hA5A5_5A5A, lat, rd, mis);
`ifdef GS_MISALIGN_TRAP_EN
        check("trap_latency", lat, 2);
        check("trap_flag", {31'b0, mis}, 32'h1);
        check("trap_rdata", rd, 32'h0);
`else
        check("lw_align_addr", seen_addr, 32'h400);
        check("lw_align_be", {28'b0, seen_be}, 32'hF);
        check("lw_align_flag", {31'b0, mis}, 32'h0);
        check("lw_align_rdata", rd, 32'hA5A5_5A5A);
`endif
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gs_mem_arbiter.md
Name: gs_mem_arbiter

Overview:
Sequencer that shares the single core memory port between instruction fetch (IF) and the data path (load/store driven by the decoder's MemRead/MemWrite/DataSize controls). It arbitrates between the two requesters and drives a req/gnt/rvalid memory handshake with one transaction outstanding. It produces byte enables and store-data lane placement, and sign/zero-extends load data from the funct3 size code. Sits between the IF/MEM pipeline stages and the memory interface.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while a fetch is pending before fetch is forced to win (1..15)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held high until if_valid
if_addr  in  32  fetch address (word aligned)
if_valid  out  1  fetch complete, 1-cycle pulse
if_rdata  out  32  fetched instruction, valid with if_valid
dm_req  in  1  data request; held high until dm_valid
dm_we  in  1  1 = store (MemWrite), 0 = load (MemRead)
dm_size  in  3  funct3 size code (LB/LH/LW/LBU/LHU, SB/SH/SW)
dm_addr  in  32  byte address from ALU
dm_wdata  in  32  store data, low-aligned
dm_valid  out  1  data access complete, 1-cycle pulse
dm_rdata  out  32  extended load data, valid with dm_valid (0 for stores)
dm_misalign  out  1  misaligned/illegal access (feature only)
mem_req  out  1  memory request
mem_we  out  1  memory write
mem_addr  out  32  word address (addr[1:0] = 0)
mem_be  out  4  byte enables
mem_wdata  out  32  lane-shifted store data
mem_gnt  in  1  memory accepted request
mem_rvalid  in  1  response/write-ack
mem_rdata  in  32  raw read word

Behaviour:
- Reset (rst=0, async): state IDLE, starve counter 0. All outputs are 0.
- States: IDLE, ISSUE_IF, ISSUE_DM, RESP_IF, RESP_DM.
- IDLE arbitration, sampled on clk edge:
  - only one req high: grant it.
  - both high: DM wins, unless starve_cnt == STARVE_LIMIT, in which case IF wins.
  - Transition to ISSUE_x; mem_* signals are registered on entry.
- ISSUE_x: mem_req=1 and mem_addr/we/be/wdata stay stable until mem_gnt. On mem_gnt, go to RESP_x and drop mem_req in the same edge.
- RESP_x: wait for mem_rvalid. On mem_rvalid, x_valid=1 combinationally in that cycle (rdata extended from mem_rdata), then return to IDLE.
- Minimum latency: req seen at cycle 0 → mem_req at cycle 1 → (gnt at 1, rvalid at 2) → valid at cycle 2. Minimum throughput is one transaction per 3 cycles.
- Stores use the same flow; mem_rvalid is the write ack and dm_rdata = 0.
- Starve counter:
  - increments on each DM grant made while if_req=1, saturating at STARVE_LIMIT.
  - clears on any IF grant.
- Byte enables and store data:
  - byte: be = 1 << addr[1:0].
  - half: be = 0011 << addr[1:0].
  - word: be = 1111.
  - wdata is replicated/shifted to the addressed lane.
- Load extension:
  - select byte/half by addr[1:0].
  - sign-extend for 000/001, zero-extend for 100/101; word passes through.
- Boundaries:
  - mem_rvalid in IDLE/ISSUE is ignored.
  - A req dropping before valid is a protocol error: the transaction still completes and no valid is lost.
  - if_req and dm_req are not re-sampled until IDLE.
  - Async reset mid-transaction aborts to IDLE; a late mem_rvalid after reset is ignored.

Optional Feature:
GS_MISALIGN_TRAP_EN
- Defined:
  - half with addr[0]=1, word with addr[1:0]≠0, or size 011/110/111 means no memory access is issued.
  - The next cycle pulses dm_valid with dm_misalign=1 and dm_rdata=0. Starve counter unchanged.
- Undefined:
  - dm_misalign tied 0.
  - Address is aligned down to the access size; illegal sizes are treated as word.

Decomposition:
- gs_pkg:
  - mem_arb_state_t enum.
  - size localparams SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b010, SZ_BU=3'b100, SZ_HU=3'b101.
- One combinational sub-module gs_lsu_align: dm_size + addr[1:0] + wdata/rdata → be, shifted wdata, extended rdata, misalign flag.

Test Plan:
- Fetch only: if_req, if_addr=0x100, gnt at cycle 1, rvalid at 2 with rdata=0x00500093 → mem_addr=0x100, be=1111, if_valid at cycle 2, if_rdata=0x00500093.
- LB sign: dm_addr=0x203, size=000, mem_rdata=0x80FFFFFF → be=1000, dm_rdata=0xFFFFFF80; same with size=100 → 0x00000080.
- SH: dm_addr=0x302, wdata=0x0000ABCD → mem_addr=0x300, be=1100, mem_wdata[31:16]=0xABCD, dm_valid on ack, dm_rdata=0.
- Contention: both reqs held continuously, zero-wait memory → grant sequence DM,DM,DM,DM,IF, repeating with STARVE_LIMIT=4.
- Gnt stall: mem_gnt low 5 cycles → mem_req, mem_addr, mem_be stable all 5 cycles; no valid until rvalid.
- Reset in RESP_DM, then rvalid 1 cycle after release → all outputs 0, state IDLE, no dm_valid. With GS_MISALIGN_TRAP_EN, LW at 0x402 → no mem_req, dm_valid+dm_misalign next cycle.
